// File: rtl/bigmul_operand_loader.sv
// Operand front-end for the CSA big multiplier: load A/B limbs, zero-pad to operand_size, pulse start, report done.
// Latency: cache writes, start, done and err_cfg are registered (one cycle after the deciding cycle); accept-to-start is 2*size+2 with no stalls.
// Backpressure: in_ready is high only while loading (from state alone); stalls on in_valid are unbounded, cfg_ready is high only in IDLE.
//
// Ports: cfg_* = one configuration per multiply; in_* = limb stream (A then B, LS limb first);
//        a_we/b_we/wr_addr/wr_data = registered cache write port; operand_size/start/mul_busy/compute_done = multiplier side;
//        done/err_cfg = one-cycle status pulses; busy = not idle.
module bigmul_operand_loader #(
    parameter int WORD_W    = 64,
    parameter int MAX_WORDS = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic [31:0]       cfg_size,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              a_we,
    output logic              b_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [31:0]       operand_size,
    output logic              start,
    input  logic              mul_busy,
    input  logic              compute_done,
    output logic              done,
    output logic              err_cfg,
    output logic              busy
);

    // One extra bit so a count of MAX_WORDS (== 2**ADDR_W) is representable.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_PAD_A, S_LOAD_B, S_PAD_B, S_START, S_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  size_q, size_d;
    logic [31:0]       operand_size_q, operand_size_d;
    logic              a_we_q, a_we_d;
    logic              b_we_q, b_we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              err_cfg_q, err_cfg_d;

    logic             cfg_ok;
    logic             hs;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_limb;
    logic             last_pad;
    logic             needs_pad;

    // Validity: non-empty, fits the cache, and the streamed length fits inside the padded size.
    assign cfg_ok = (cfg_len != '0) && (cfg_size != 32'd0) &&
                    (cfg_size <= 32'(MAX_WORDS)) && (32'(cfg_len) <= cfg_size);

    assign cfg_ready = (state_q == S_IDLE);
    assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign busy      = (state_q != S_IDLE);
    assign hs        = in_valid && in_ready;

    assign cnt_inc   = cnt_q + CNT_ONE;
    assign last_limb = (cnt_inc == len_q);
    assign last_pad  = (cnt_inc == size_q);
    assign needs_pad = (len_q < size_q);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cfg_valid && cfg_ok) state_d = S_LOAD_A;
            S_LOAD_A: if (hs && last_limb) state_d = needs_pad ? S_PAD_A : S_LOAD_B;
            S_PAD_A:  if (last_pad) state_d = S_LOAD_B;
            S_LOAD_B: if (hs && last_limb) state_d = needs_pad ? S_PAD_B : S_START;
            S_PAD_B:  if (last_pad) state_d = S_START;
            S_START:  if (!mul_busy) state_d = S_WAIT;
            S_WAIT:   if (compute_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        cnt_d          = cnt_q;
        len_d          = len_q;
        size_d         = size_q;
        operand_size_d = operand_size_q;
        a_we_d         = 1'b0;
        b_we_d         = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        start_d        = 1'b0;
        done_d         = 1'b0;
        err_cfg_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_ok) begin
                        len_d          = cfg_len;
                        // Safe truncation: cfg_ok bounds cfg_size to MAX_WORDS.
                        size_d         = cfg_size[CNT_W-1:0];
                        operand_size_d = cfg_size;
                        cnt_d          = '0;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                if (hs) begin
                    a_we_d    = (state_q == S_LOAD_A);
                    b_we_d    = (state_q == S_LOAD_B);
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = in_data;
                    // Keep counting into the pad region; restart only when no pad follows.
                    cnt_d     = (last_limb && !needs_pad) ? '0 : cnt_inc;
                end
            end
            S_PAD_A, S_PAD_B: begin
                a_we_d    = (state_q == S_PAD_A);
                b_we_d    = (state_q == S_PAD_B);
                wr_addr_d = cnt_q[ADDR_W-1:0];
                wr_data_d = '0;
                cnt_d     = last_pad ? '0 : cnt_inc;
            end
            S_START: begin
                if (!mul_busy) start_d = 1'b1;
            end
            S_WAIT: begin
                if (compute_done) done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q          <= '0;
            len_q          <= '0;
            size_q         <= '0;
            operand_size_q <= '0;
            a_we_q         <= 1'b0;
            b_we_q         <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            start_q        <= 1'b0;
            done_q         <= 1'b0;
            err_cfg_q      <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            len_q          <= len_d;
            size_q         <= size_d;
            operand_size_q <= operand_size_d;
            a_we_q         <= a_we_d;
            b_we_q         <= b_we_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            start_q        <= start_d;
            done_q         <= done_d;
            err_cfg_q      <= err_cfg_d;
        end
    end

    assign a_we         = a_we_q;
    assign b_we         = b_we_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign operand_size = operand_size_q;
    assign start        = start_q;
    assign done         = done_q;
    assign err_cfg      = err_cfg_q;

endmodule

// File: tb/tb_bigmul_operand_loader.sv
// Bench for bigmul_operand_loader: directed cases plus randomized transactions against a behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are observed on the falling edge.
// A negedge monitor models the expected cache-write sequence, start/done/err_cfg pulses and handshake state.
module tb_bigmul_operand_loader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [6:0]  cfg_len;
    logic [31:0] cfg_size;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        a_we, b_we;
    logic [5:0]  wr_addr;
    logic [63:0] wr_data;
    logic [31:0] operand_size;
    logic        start;
    logic        mul_busy;
    logic        compute_done;
    logic        done;
    logic        err_cfg;
    logic        busy;

    bigmul_operand_loader #(.WORD_W(64), .MAX_WORDS(64), .ADDR_W(6)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len), .cfg_size(cfg_size),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .a_we(a_we), .b_we(b_we), .wr_addr(wr_addr), .wr_data(wr_data),
        .operand_size(operand_size), .start(start), .mul_busy(mul_busy),
        .compute_done(compute_done), .done(done), .err_cfg(err_cfg), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit cfg_ok(input int len, input longint size);
        return (len != 0) && (size != 0) && (len <= size) && (size <= 64);
    endfunction

    // ---------------- behavioural monitor ----------------
    logic [63:0] mem_a [64];
    logic [63:0] mem_b [64];
    logic [63:0] la [64];
    logic [63:0] lb [64];
    bit          txn_active = 0;
    int          m_len, m_size;
    int          a_cnt = 0, b_cnt = 0;
    int          n_start = 0, n_start_total = 0;
    int          n_err_pulse = 0, n_wr_total = 0;
    int          acc_cyc, start_cyc;
    int          last_b_addr;
    bit          done_seen = 0;
    bit          hs_prev = 0;
    logic [63:0] hs_data_prev;
    bit          start_due = 0, done_due = 0, err_pend = 0;
    logic [63:0] e_data;

    always @(negedge clk) begin
        if (!rstn) begin
            txn_active = 0; hs_prev = 0; start_due = 0; done_due = 0; err_pend = 0;
            a_cnt = 0; b_cnt = 0; n_start = 0; done_seen = 0;
        end else begin
            if (a_we && b_we) chk("we_both", 1, 0);
            if (hs_prev && !(a_we || b_we)) chk("wr_missing", 0, 1);
            if (a_we || b_we) begin
                n_wr_total++;
                if (!txn_active) begin
                    chk("wr_idle", 1, 0);
                end else if (a_cnt < m_size) begin
                    // A words arrive in address order: limbs first, zero pad after.
                    e_data = (a_cnt < m_len) ? hs_data_prev : 64'd0;
                    chk("a_target", a_we, 1);
                    chk("a_addr", wr_addr, a_cnt);
                    chk("a_src_hs", hs_prev, a_cnt < m_len);
                    chk("a_data", wr_data, e_data);
                    mem_a[wr_addr] = wr_data;
                    a_cnt++;
                end else if (b_cnt < m_size) begin
                    e_data = (b_cnt < m_len) ? hs_data_prev : 64'd0;
                    chk("b_target", b_we, 1);
                    chk("b_addr", wr_addr, b_cnt);
                    chk("b_src_hs", hs_prev, b_cnt < m_len);
                    chk("b_data", wr_data, e_data);
                    mem_b[wr_addr] = wr_data;
                    last_b_addr = wr_addr;
                    b_cnt++;
                end else begin
                    chk("wr_extra", 1, 0);
                end
            end
            hs_prev      = in_valid && in_ready;
            hs_data_prev = in_data;

            if (start || start_due) chk("start", start, start_due);
            if (start) begin n_start++; n_start_total++; start_cyc = cyc; end

            if (done || done_due) chk("done", done, done_due);
            if (done) begin done_seen = 1; txn_active = 0; end

            if (err_cfg || err_pend) chk("err_cfg", err_cfg, err_pend);
            if (err_cfg) n_err_pulse++;

            chk("cfg_ready", cfg_ready, !txn_active);
            chk("busy", busy, txn_active);

            err_pend = 0;
            if (cfg_valid && cfg_ready) begin
                if (cfg_ok(int'(cfg_len), longint'(cfg_size))) begin
                    txn_active = 1; m_len = cfg_len; m_size = cfg_size;
                    a_cnt = 0; b_cnt = 0; n_start = 0; done_seen = 0; acc_cyc = cyc;
                    for (int i = 0; i < 64; i++) begin mem_a[i] = 'x; mem_b[i] = 'x; end
                end else begin
                    err_pend = 1;
                end
            end
            // Start is owed the cycle after all B words are written and the multiplier is idle.
            start_due = txn_active && (b_cnt == m_size) && (n_start == 0) && !mul_busy;
            done_due  = txn_active && (n_start > 0) && !done_seen && compute_done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"}, cfg_ready, 1);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_we"}, {a_we, b_we}, 0);
        chk({tag, "_pulses"}, {start, done, err_cfg}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_opsize"}, operand_size, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            la[i] = {$urandom, $urandom};
            lb[i] = {$urandom, $urandom};
        end
    endtask

    task automatic run_txn(input int len, input int size, input int vpct,
                           input logic [15:0] vpat, input int vpat_len,
                           input int busy_extra, input bit junk_cfg);
        int idx;
        int g;
        idx = 0; g = 0;
        cfg_valid = 1; cfg_len = 7'(len); cfg_size = size;
        tick();
        cfg_valid = 0;
        mul_busy  = (busy_extra > 0);
        while (idx < 2 * len && g < 4000) begin
            in_valid = (vpat_len > 0) ? vpat[g % vpat_len] : ($urandom_range(99) < vpct);
            in_data  = (idx < len) ? la[idx] : lb[idx - len];
            if (junk_cfg) begin
                cfg_valid = 1'($urandom_range(1)); cfg_len = 7'($urandom); cfg_size = $urandom_range(70);
            end
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            tick();
            g++;
        end
        in_valid = 0; cfg_valid = 0; in_data = {$urandom, $urandom};
        if (idx < 2 * len) chk("stream_timeout", idx, 2 * len);
        g = 0;
        while (b_cnt < size && g < 300) begin tick(); g++; end
        if (b_cnt < size) chk("b_write_timeout", b_cnt, size);
        repeat (busy_extra) @(posedge clk);
        #1 mul_busy = 0;
        g = 0;
        while (n_start == 0 && g < 300) begin tick(); g++; end
        if (n_start == 0) chk("start_timeout", 0, 1);
        repeat ($urandom_range(4)) @(posedge clk);
        #1 compute_done = 1;
        tick();
        compute_done = 0;
        g = 0;
        while (!done_seen && g < 50) begin tick(); g++; end
        chk("done_seen", done_seen, 1);
        chk("a_writes", a_cnt, size);
        chk("b_writes", b_cnt, size);
        chk("start_count", n_start, 1);
        chk("operand_size", operand_size, size);
        chk("last_b_addr", last_b_addr, size - 1);
        for (int i = 0; i < size; i++) begin
            chk("mem_a", mem_a[i], (i < len) ? la[i] : 64'd0);
            chk("mem_b", mem_b[i], (i < len) ? lb[i] : 64'd0);
        end
        if (vpct == 100 && vpat_len == 0 && busy_extra == 0)
            chk("start_latency", start_cyc - acc_cyc, 2 * size + 2);
        // A stray compute_done while idle must not produce done (monitor checks).
        compute_done = 1;
        tick();
        compute_done = 0;
        tick();
    endtask

    task automatic run_bad(input int len, input int size);
        int e0, w0;
        logic [31:0] os;
        e0 = n_err_pulse; w0 = n_wr_total; os = operand_size;
        cfg_valid = 1; cfg_len = 7'(len); cfg_size = size;
        tick();
        cfg_valid = 0;
        repeat (3) tick();
        chk("bad_err_count", n_err_pulse - e0, 1);
        chk("bad_busy", busy, 0);
        chk("bad_no_write", n_wr_total - w0, 0);
        chk("bad_opsize", operand_size, os);
    endtask

    initial begin
        int s0, g, len, size;
        rstn = 0; cfg_valid = 0; cfg_len = 0; cfg_size = 0;
        in_valid = 0; in_data = 0; mul_busy = 0; compute_done = 0;
        repeat (3) @(posedge clk);
        #3 check_reset_outputs("rst");
        tick();
        rstn = 1;
        tick();

        // Normal load
        for (int i = 0; i < 4; i++) begin la[i] = i + 1; lb[i] = i + 5; end
        run_txn(4, 6, 100, 16'h0, 0, 0, 0);

        // Full width, no padding
        for (int i = 0; i < 64; i++) begin la[i] = 64'h7fffffffffffffff; lb[i] = 64'h7fffffffffffffff; end
        run_txn(64, 64, 100, 16'h0, 0, 0, 0);

        // Backpressure: in_valid 1,0,0,1,0,1 repeating
        fill_random();
        run_txn(3, 3, 0, 16'b101001, 6, 0, 0);

        // Configuration errors
        run_bad(0, 4);
        run_bad(5, 4);
        run_bad(4, 65);
        run_bad(3, 0);

        // Busy multiplier
        fill_random();
        run_txn(2, 3, 100, 16'h0, 0, 10, 0);

        // Reset mid-load after two A writes
        fill_random();
        cfg_valid = 1; cfg_len = 4; cfg_size = 6;
        tick();
        cfg_valid = 0;
        g = 0; len = 0;
        while (a_cnt < 2 && g < 50) begin
            in_valid = 1; in_data = la[len];
            @(negedge clk);
            if (in_ready) len++;
            tick();
            g++;
        end
        chk("pre_reset_a_writes", a_cnt, 2);
        #1 rstn = 0;
        #1 check_reset_outputs("midrst");
        in_valid = 0; compute_done = 1;
        s0 = n_start_total;
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        repeat (2) tick();
        compute_done = 0;
        repeat (4) tick();
        chk("midrst_no_start", n_start_total - s0, 0);
        la[0] = 64'h1111; lb[0] = 64'h2222;
        run_txn(1, 1, 100, 16'h0, 0, 0, 0);

        // Randomized transactions
        for (int t = 0; t < 12; t++) begin
            fill_random();
            size = $urandom_range(64, 1);
            len  = $urandom_range(size, 1);
            run_txn(len, size, $urandom_range(100, 30), 16'h0, 0, $urandom_range(5), 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bigmul_operand_loader.md
# bigmul_operand_loader

Operand front-end for `bigmul_unit_csa`. Accepts one configuration per multiply, then a valid/ready stream of 64-bit limbs (A limbs, then B limbs, least significant first). Writes them into the multiplier's A/B operand caches, zero-pads each operand up to `operand_size` words, and pulses `start`. It then waits for `compute_done` and reports completion upstream.

## Interface
- `WORD_W`, 64, limb width in bits
- `MAX_WORDS`, 64, operand cache depth in words
- `ADDR_W`, 6, cache address width; `2**ADDR_W >= MAX_WORDS`
- `clk  in  1  clock; all state on rising edge`
- `rstn  in  1  reset; asynchronous assert, active-low`
- `cfg_valid  in  1  configuration offered`
- `cfg_ready  out  1  high only in IDLE`
- `cfg_len  in  ADDR_W+1  limbs streamed per operand`
- `cfg_size  in  32  padded operand length in words`
- `in_valid  in  1  limb offered`
- `in_ready  out  1  high only in LOAD_A / LOAD_B`
- `in_data  in  WORD_W  limb value`
- `a_we  out  1  cache A write strobe`
- `b_we  out  1  cache B write strobe`
- `wr_addr  out  ADDR_W  cache word address`
- `wr_data  out  WORD_W  cache write data`
- `operand_size  out  32  size driven to multiplier; holds last accepted `cfg_size``
- `start  out  1  one-cycle start pulse to multiplier`
- `mul_busy  in  1  multiplier busy`
- `compute_done  in  1  multiplier completion`
- `done  out  1  one-cycle pulse when the multiply completes`
- `err_cfg  out  1  one-cycle pulse on a rejected configuration`
- `busy  out  1  high in every state except IDLE`

## Operation
- FSM states: IDLE, LOAD_A, PAD_A, LOAD_B, PAD_B, START, WAIT.
- IDLE:
  - A configuration is accepted when `cfg_valid & cfg_ready` are both high.
  - A configuration is invalid if `cfg_len == 0`, `cfg_size == 0`, `cfg_len > cfg_size`, or `cfg_size > MAX_WORDS`.
  - Invalid configuration: `err_cfg` pulses, the FSM stays in IDLE, and `operand_size` is unchanged.
  - Valid configuration: latch `len` and `size`, drive `operand_size = cfg_size`, clear the word counter, and go to LOAD_A.
- LOAD_A:
  - Each `in_valid & in_ready` handshake writes `in_data` to A at address = counter, then increments the counter.
  - After handshake number `len`: go to PAD_A if `len < size`, else to LOAD_B with the counter cleared.
- PAD_A: writes 0 to A, one word per cycle, at addresses `len .. size-1`. Then go to LOAD_B with the counter cleared.
- LOAD_B and PAD_B: identical to LOAD_A and PAD_A, but target cache B. After the last B write, go to START.
- START:
  - Wait while `mul_busy == 1`.
  - The first cycle with `mul_busy == 0`: assert `start` for exactly one cycle, then go to WAIT.
- WAIT:
  - On `compute_done == 1`: pulse `done` and go to IDLE.
  - `compute_done` is ignored in all other states.
- Cache addresses never exceed `size-1`. Addresses `size .. MAX_WORDS-1` are never written.
- Exactly one of `a_we` / `b_we` is high per write cycle. They are never high together.
- In IDLE, START and WAIT, no write strobe is asserted and `in_ready` is 0.

## Timing
- Reset (async assert, synchronous release):
  - state = IDLE; `cfg_ready = 1`.
  - `in_ready = 0`; `a_we`, `b_we`, `start`, `done`, `err_cfg`, `busy` = 0.
  - `wr_addr`, `wr_data`, `operand_size` = 0.
- Write port is registered. `a_we`/`b_we`, `wr_addr` and `wr_data` are valid in the cycle after the handshake or pad decision. That is one cycle of latency.
- `in_ready` is combinational from state only. It does not depend on `in_valid`.
- With `in_valid` held high, from config accept to the `start` pulse takes `2*size + 2` cycles, assuming `mul_busy` is low.
- `done` pulses in the cycle after `compute_done` is sampled high in WAIT.
- Backpressure: if `in_valid` is low, nothing is written and the counter holds. A stall in any LOAD state is unbounded.
- `cfg_valid` outside IDLE is ignored. `cfg_ready` is 0 there, so no configuration is lost.
- Reset mid-operation:
  - Immediate return to IDLE; any partial cache contents are abandoned.
  - No `start` is issued.
  - A pending `compute_done` after reset is ignored.

## Test plan
- Normal load:
  - Stimulus: config len=4, size=6; A limbs 1,2,3,4; B limbs 5,6,7,8; `in_valid` held high.
  - Required response: A[0..5] = 1,2,3,4,0,0 and B[0..5] = 5,6,7,8,0,0.
  - Exactly one `start` pulse, 14 cycles after config accept.
  - `operand_size = 6`.
- Full width:
  - Stimulus: len = size = 64, all limbs `64'h7fffffffffffffff`.
  - Required response: no pad cycles occur; 128 writes, last `wr_addr = 63` on `b_we`.
  - `start` pulses once.
  - `done` pulses one cycle after `compute_done`.
- Backpressure:
  - Stimulus: len=3, size=3; `in_valid` toggles 1,0,0,1,0,1.
  - Required response: exactly 3 A writes at addresses 0,1,2, with no writes during low-valid cycles.
- Config errors: each of len=0, len=5/size=4, and size=65 produces one `err_cfg` pulse, the FSM stays IDLE, and no write strobe is asserted.
- Busy multiplier:
  - Stimulus: `mul_busy` held high for 10 cycles after the last B write.
  - Required response: `start` is asserted in the first cycle after `mul_busy` falls, and only once.
- Reset mid-load:
  - Stimulus: drop `rstn` after 2 A limbs have been written.
  - Required response: all outputs return to their reset values.
  - A new len=1, size=1 config then completes normally with A[0], B[0] written.
